pic_cycle_ctrl: RTL and testbench

Four-phase (Q1–Q4) instruction-cycle sequencer for the structural PIC datapath. It takes per-instruction control fields from the combinational instruction decoder and generates the phase-aligned strobes for the status register (`out_en`, `write_en`, `carry_wr`, `zero_wr`), register file, W register, ALU bus driver, IR and PC. It also squashes the instruction cycle that follows a taken skip or a jump (pipeline flush).

---
 rtl/pic_cycle_ctrl_if.sv | 43 ++++
 rtl/pic_cycle_ctrl.sv | 126 ++++++++++++
 tb/tb_pic_cycle_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pic_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pic_cycle_ctrl_if
//  Purpose  : Decoder-field inputs and phase-aligned strobes of the PIC
//             Q1-Q4 instruction-cycle sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface pic_cycle_ctrl_if;
    logic       run;
    logic [2:0] op_class;
    logic       dest_f;
    logic       sel_status;
    logic       aff_c;
    logic       aff_z;
    logic       skip_cond;

    logic [1:0] phase;
    logic       flushing;
    logic       rf_oe;
    logic       status_oe;
    logic       alu_oe;
    logic       carry_wr;
    logic       zero_wr;
    logic       rf_we;
    logic       status_we;
    logic       w_we;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;

    modport master (
        output run, op_class, dest_f, sel_status, aff_c, aff_z, skip_cond,
        input  phase, flushing, rf_oe, status_oe, alu_oe, carry_wr, zero_wr,
               rf_we, status_we, w_we, ir_load, pc_inc, pc_load
    );

    modport slave (
        input  run, op_class, dest_f, sel_status, aff_c, aff_z, skip_cond,
        output phase, flushing, rf_oe, status_oe, alu_oe, carry_wr, zero_wr,
               rf_we, status_we, w_we, ir_load, pc_inc, pc_load
    );
endinterface
`default_nettype wire

// File: rtl/pic_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pic_cycle_ctrl
//  Purpose  : Four-phase Q1-Q4 sequencer producing datapath strobes, with a
//             one-cycle squash after a taken skip or a jump.
//  Revision : 1.0  initial release
// ============================================================================
module pic_cycle_ctrl (
    input  wire logic         clock,
    input  wire logic         reset,
    pic_cycle_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_t;

    localparam logic [2:0] C_OP_ALU_RF  = 3'd1;
    localparam logic [2:0] C_OP_ALU_LIT = 3'd2;
    localparam logic [2:0] C_OP_SKIP    = 3'd3;
    localparam logic [2:0] C_OP_JUMP    = 3'd4;

    phase_t r_phase, w_phase_nxt;
    logic   r_flush, w_flush_nxt;
    logic   r_skip,  w_skip_nxt;

    logic w_is_rf, w_is_lit, w_is_skip, w_is_jump, w_live;
    logic w_rf_oe, w_status_oe, w_alu_oe, w_carry_wr, w_zero_wr;
    logic w_rf_we, w_status_we, w_w_we, w_ir_load, w_pc_inc, w_pc_load;

    assign w_is_rf   = (bus.op_class == C_OP_ALU_RF);
    assign w_is_lit  = (bus.op_class == C_OP_ALU_LIT);
    assign w_is_skip = (bus.op_class == C_OP_SKIP);
    assign w_is_jump = (bus.op_class == C_OP_JUMP);
    // Strobes are gated by reset as well so they drop the instant it asserts.
    assign w_live    = bus.run & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_phase <= Q1;
            r_flush <= 1'b1;
            r_skip  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_flush <= w_flush_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_flush_nxt = r_flush;
        w_skip_nxt  = r_skip;
        w_rf_oe     = 1'b0;
        w_status_oe = 1'b0;
        w_alu_oe    = 1'b0;
        w_carry_wr  = 1'b0;
        w_zero_wr   = 1'b0;
        w_rf_we     = 1'b0;
        w_status_we = 1'b0;
        w_w_we      = 1'b0;
        w_ir_load   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;

        if (bus.run) begin
            w_phase_nxt = phase_t'(r_phase + 2'd1);
            if (r_phase == Q3 && !r_flush && w_is_skip && bus.skip_cond) begin
                w_skip_nxt = 1'b1;
            end
            // A squashed cycle always ends the flush and can never start another.
            if (r_phase == Q4) begin
                w_flush_nxt = !r_flush && (r_skip || w_is_jump);
                w_skip_nxt  = 1'b0;
            end
        end

        if (w_live) begin
            case (r_phase)
                Q2: begin
                    if (!r_flush && (w_is_rf || w_is_skip)) begin
                        w_status_oe = bus.sel_status;
                        w_rf_oe     = !bus.sel_status;
                    end
                end
                Q3: begin
                    if (!r_flush && (w_is_rf || w_is_lit)) begin
                        w_carry_wr = bus.aff_c;
                        w_zero_wr  = bus.aff_z;
                    end
                end
                Q4: begin
                    w_ir_load = 1'b1;
                    if (r_flush) begin
                        w_pc_inc = 1'b1;
                    end else begin
                        w_pc_load   = w_is_jump;
                        w_pc_inc    = !w_is_jump;
                        w_alu_oe    = w_is_rf || w_is_lit;
                        w_rf_we     = w_is_rf && bus.dest_f && !bus.sel_status;
                        w_status_we = w_is_rf && bus.dest_f && bus.sel_status;
                        w_w_we      = w_is_lit || (w_is_rf && !bus.dest_f);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.phase     = r_phase;
    assign bus.flushing  = r_flush;
    assign bus.rf_oe     = w_rf_oe;
    assign bus.status_oe = w_status_oe;
    assign bus.alu_oe    = w_alu_oe;
    assign bus.carry_wr  = w_carry_wr;
    assign bus.zero_wr   = w_zero_wr;
    assign bus.rf_we     = w_rf_we;
    assign bus.status_we = w_status_we;
    assign bus.w_we      = w_w_we;
    assign bus.ir_load   = w_ir_load;
    assign bus.pc_inc    = w_pc_inc;
    assign bus.pc_load   = w_pc_load;
endmodule
`default_nettype wire

// File: tb/tb_pic_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pic_cycle_ctrl
//  Purpose  : Directed plus randomized bench for pic_cycle_ctrl against an
//             instruction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pic_cycle_ctrl;
    logic clock;
    logic reset;

    pic_cycle_ctrl_if bus_if ();

    pic_cycle_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int tick_no = 0;

    // Model: position within the instruction cycle, whether this cycle is
    // squashed, and whether the current skip has been taken.
    int m_pos    = 0;
    bit m_squash = 1'b1;
    bit m_taken  = 1'b0;

    function automatic int cls_of(input logic [2:0] oc);
        return (oc > 3'd4) ? 0 : int'(oc);
    endfunction

    function automatic logic [13:0] model_out();
        logic [1:0] ph;
        bit rf_oe, st_oe, alu_oe, c_wr, z_wr, rf_we, st_we, w_we, ir, inc, ld;
        int cls;
        cls = cls_of(bus_if.op_class);
        ph = m_pos[1:0];
        {rf_oe, st_oe, alu_oe, c_wr, z_wr, rf_we, st_we, w_we, ir, inc, ld} = '0;
        if (reset && bus_if.run) begin
            if (m_squash) begin
                if (m_pos == 3) begin
                    ir  = 1'b1;
                    inc = 1'b1;
                end
            end else if (m_pos == 1) begin
                if (cls == 1 || cls == 3) begin
                    st_oe = bus_if.sel_status;
                    rf_oe = !bus_if.sel_status;
                end
            end else if (m_pos == 2) begin
                if (cls == 1 || cls == 2) begin
                    c_wr = bus_if.aff_c;
                    z_wr = bus_if.aff_z;
                end
            end else if (m_pos == 3) begin
                ir     = 1'b1;
                ld     = (cls == 4);
                inc    = (cls != 4);
                alu_oe = (cls == 1 || cls == 2);
                rf_we  = (cls == 1) && bus_if.dest_f && !bus_if.sel_status;
                st_we  = (cls == 1) && bus_if.dest_f && bus_if.sel_status;
                w_we   = (cls == 2) || (cls == 1 && !bus_if.dest_f);
            end
        end
        return {ph, m_squash, rf_oe, st_oe, alu_oe, c_wr, z_wr, rf_we, st_we, w_we, ir, inc, ld};
    endfunction

    task automatic model_reset();
        m_pos    = 0;
        m_squash = 1'b1;
        m_taken  = 1'b0;
    endtask

    task automatic model_edge();
        int cls;
        cls = cls_of(bus_if.op_class);
        if (!reset) begin
            model_reset();
        end else if (bus_if.run) begin
            if (m_pos == 2 && !m_squash && cls == 3 && bus_if.skip_cond) m_taken = 1'b1;
            if (m_pos == 3) begin
                m_squash = !m_squash && (m_taken || cls == 4);
                m_taken  = 1'b0;
            end
            m_pos = (m_pos + 1) % 4;
        end
    endtask

    task automatic check(input string tag);
        logic [13:0] obs, exp;
        exp = model_out();
        obs = {bus_if.phase, bus_if.flushing, bus_if.rf_oe, bus_if.status_oe, bus_if.alu_oe,
               bus_if.carry_wr, bus_if.zero_wr, bus_if.rf_we, bus_if.status_we, bus_if.w_we,
               bus_if.ir_load, bus_if.pc_inc, bus_if.pc_load};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s tick=%0d observed=%b expected=%b", tag, tick_no, obs, exp);
        end
        checks++;
        assert ($countones({bus_if.rf_oe, bus_if.status_oe, bus_if.alu_oe}) <= 1) else begin
            errors++;
            $error("FAIL bus_drivers tick=%0d observed=%b expected=at most one",
                   tick_no, {bus_if.rf_oe, bus_if.status_oe, bus_if.alu_oe});
        end
        checks++;
        assert (!(bus_if.pc_inc && bus_if.pc_load) && !(bus_if.rf_we && bus_if.status_we)) else begin
            errors++;
            $error("FAIL exclusive_strobes tick=%0d observed=%b expected=no pair both 1",
                   tick_no, {bus_if.pc_inc, bus_if.pc_load, bus_if.rf_we, bus_if.status_we});
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick(input string tag);
        #1;
        if (!reset) model_reset();
        check(tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        tick_no++;
    endtask

    task automatic instr(input string tag, input logic [2:0] cls, input bit d, input bit s,
                         input bit c, input bit z, input bit sk);
        bus_if.op_class   = cls;
        bus_if.dest_f     = d;
        bus_if.sel_status = s;
        bus_if.aff_c      = c;
        bus_if.aff_z      = z;
        bus_if.skip_cond  = sk;
        bus_if.run        = 1'b1;
        repeat (4) tick(tag);
    endtask

    initial begin
        reset = 1'b0;
        bus_if.run = 1'b1;
        bus_if.op_class = 3'd0;
        bus_if.dest_f = 1'b0;
        bus_if.sel_status = 1'b0;
        bus_if.aff_c = 1'b0;
        bus_if.aff_z = 1'b0;
        bus_if.skip_cond = 1'b0;
        @(negedge clock);
        tick("reset_hold");
        tick("reset_hold");
        reset = 1'b1;

        instr("nop_flushed", 3'd0, 0, 0, 0, 0, 0);
        instr("nop",         3'd0, 0, 0, 0, 0, 0);
        instr("nop",         3'd7, 0, 0, 0, 0, 0);
        instr("alurf_status",3'd1, 1, 1, 1, 1, 0);
        instr("alulit_z",    3'd2, 0, 0, 0, 1, 0);
        instr("skip_taken",  3'd3, 0, 0, 0, 0, 1);
        instr("squashed_rf", 3'd1, 1, 0, 1, 1, 0);
        instr("skip_not",    3'd3, 0, 1, 0, 0, 0);
        instr("alurf_file",  3'd1, 1, 0, 1, 0, 0);
        instr("jump",        3'd4, 0, 0, 0, 0, 0);
        instr("jump_squash", 3'd4, 0, 0, 0, 0, 0);
        instr("alurf_w",     3'd1, 0, 0, 0, 1, 0);

        // Stall in Q2 of an ALU_RF, resume, then reset in Q3.
        bus_if.op_class = 3'd1;
        bus_if.dest_f = 1'b1;
        bus_if.sel_status = 1'b0;
        bus_if.aff_c = 1'b1;
        bus_if.aff_z = 1'b0;
        tick("stall_q1");
        bus_if.run = 1'b0;
        repeat (3) tick("stall_q2");
        bus_if.run = 1'b1;
        tick("resume_q2");
        #1;
        check("q3_before_reset");
        reset = 1'b0;
        #1;
        model_reset();
        check("reset_mid_q3");
        checks++;
        assert (bus_if.carry_wr === 1'b0) else begin
            errors++;
            $error("FAIL carry_wr_on_reset observed=%b expected=0", bus_if.carry_wr);
        end
        @(negedge clock);
        tick("reset_hold2");
        reset = 1'b1;
        instr("nop_flushed2", 3'd0, 0, 0, 0, 0, 0);
        instr("alurf_after",  3'd1, 1, 1, 1, 1, 0);

        // Randomized phase: decoder fields change only at instruction boundaries.
        for (int i = 0; i < 2000; i++) begin
            if (m_pos == 0) begin
                bus_if.op_class   = 3'($urandom_range(0, 7));
                bus_if.dest_f     = 1'($urandom_range(0, 1));
                bus_if.sel_status = 1'($urandom_range(0, 1));
                bus_if.aff_c      = 1'($urandom_range(0, 1));
                bus_if.aff_z      = 1'($urandom_range(0, 1));
            end
            bus_if.skip_cond = 1'($urandom_range(0, 1));
            bus_if.run       = ($urandom_range(0, 4) != 0);
            reset            = ($urandom_range(0, 149) != 0);
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
